muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit implementing the RV32M-style operation group: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Sits beside the single-cycle ALU. Decode steers M-extension operations here instead of to the ALU's zero-result placeholders.
- Parametrised in datapath width, with a valid/ready handshake on both sides and a tag carried through for writeback.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- TAG_W, 4, width of the opaque tag passed from input to output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- funct  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- op1  in  XLEN  rs1 value
- op2  in  XLEN  rs2 value
- in_tag  in  TAG_W  request tag (e.g. rd index)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res  out  XLEN  result
- out_tag  out  TAG_W  tag of the request producing res
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: out_valid=0, res=0, out_tag=0, busy=0, state=IDLE, in_ready=1.
- FSM states: IDLE, CALC, FIX, DONE.
- Outputs: in_ready = (state==IDLE); busy = !in_ready.
- Accept: in_valid && in_ready at a clock edge. On accept, latch funct, in_tag, |op1|, |op2| and the result sign.
  - Operand signedness per funct: mul/mulh/div/rem both signed; mulhsu op1 signed, op2 unsigned; others unsigned. mul treats operands as unsigned, since the low half is sign-independent.
  - Result sign: product sign = XOR of operand signs. Quotient sign = XOR of operand signs. Remainder sign = dividend sign.
- IDLE -> CALC on accept, except in the special division cases below.
- CALC runs XLEN iterations, counted by a $clog2(XLEN)+1-bit counter.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- CALC -> FIX after the XLEN-th iteration. FIX applies two's-complement negation if the result sign is set, then selects the low half (mul, quotient, remainder) or the high half (mulh*).
- FIX -> DONE. In DONE, out_valid=1 and res/out_tag are held stable.
- DONE -> IDLE on out_ready; out_valid drops at that same edge.
- Latency: out_valid rises XLEN+1 edges after the accept edge (iterative path).
- DONE-to-IDLE and a new accept never coincide; the minimum request spacing is latency+1 cycles.
- Special division cases are detected at accept and go IDLE -> DONE directly (latency 1):
  - Divide by zero: div/divu -> all ones; rem/remu -> op1.
  - Signed overflow (op1 = 1 followed by XLEN-1 zeros, op2 = all ones, div/rem only): div -> op1; rem -> 0.
- funct is fully decoded; no illegal encodings exist.
- Reset asserted in any state, including mid-CALC: abandon the operation, emit no result, return to reset values at that edge.
- Inputs are ignored while in_ready=0, including op1, op2, funct and in_tag.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiplies (funct[2]=0) use a single-cycle signed (XLEN+1)x(XLEN+1) product on sign/zero-extended operands and go IDLE -> DONE directly, latency 1. Divides are unchanged.
- Undefined: multiplies use the iterative CALC/FIX path, latency XLEN+1. No hardware multiplier is inferred.
- Results are bit-identical in both builds.

Test Plan (XLEN=32, macro undefined unless stated):
- mul 7 x 0xFFFFFFFD -> res 0xFFFFFFEB; out_valid exactly 33 edges after accept; out_tag equals in_tag.
- mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Repeat with MULDIV_FAST_MUL_EN: same values, latency 1.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. rem same operands -> 0xFFFFFFFF. divu 100/7 -> 14. remu 100/7 -> 2.
- div 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem same -> 0. All four have latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> res/out_tag stable, in_ready=0, in_valid ignored. Then out_ready=1 -> out_valid=0 and in_ready=1 after that edge.
- Assert rst for one edge during iteration 10 of a div -> out_valid never rises for it; in_ready=1 next cycle. A new mul 3x4 then returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit with valid/ready handshakes and a pass-through tag.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a hardware multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        fn_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   prem;
    logic [CW-1:0]     cnt;

    logic              accept, sgn1, sgn2, neg1, neg2, res_neg;
    logic              div_zero, div_ovf, special, fast_hit, direct;
    logic [XLEN-1:0]   mag1, mag2, spec_res, fast_res, fix_res, qv, rv;
    logic [XLEN:0]     msum, dshift, ddiff;
    logic [2*XLEN-1:0] mneg;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;

    // Request decode: operand signedness, magnitudes, result sign and the one-cycle cases
    always_comb begin
        sgn1     = (funct == 3'b001) || (funct == 3'b010) || (funct == 3'b100) || (funct == 3'b110);
        sgn2     = (funct == 3'b001) || (funct == 3'b100) || (funct == 3'b110);
        neg1     = sgn1 && op1[XLEN-1];
        neg2     = sgn2 && op2[XLEN-1];
        mag1     = neg1 ? -op1 : op1;
        mag2     = neg2 ? -op2 : op2;
        res_neg  = (funct[2] && funct[1]) ? neg1 : (neg1 ^ neg2);
        div_zero = funct[2] && (op2 == '0);
        div_ovf  = funct[2] && !funct[0] && (op1 == MINV) && (op2 == '1);
        special  = div_zero || div_ovf;
        spec_res = '0;
        if (div_zero)
            spec_res = funct[1] ? op1 : '1;
        else if (div_ovf)
            spec_res = funct[1] ? '0 : op1;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fprod;

    // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact for every signedness mix
    always_comb begin
        fa       = {{XLEN{sgn1 && op1[XLEN-1]}}, op1};
        fb       = {{XLEN{sgn2 && op2[XLEN-1]}}, op2};
        fprod    = fa * fb;
        fast_hit = !funct[2];
        fast_res = (funct[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    assign direct = special || fast_hit;

    // One iteration step for each algorithm; the trial remainder needs XLEN+1 bits
    always_comb begin
        msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        dshift = {prem, acc[XLEN-1]};
        ddiff  = dshift - {1'b0, b_q};
    end

    always_comb begin
        mneg = neg_q ? -acc : acc;
        qv   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rv   = neg_q ? -prem : prem;
        if (fn_q[2])
            fix_res = fn_q[1] ? rv : qv;
        else
            fix_res = (fn_q[1:0] == 2'b00) ? mneg[XLEN-1:0] : mneg[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = direct ? DONE : CALC;
            CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            out_tag   <= '0;
            fn_q      <= '0;
            neg_q     <= 1'b0;
            b_q       <= '0;
            acc       <= '0;
            prem      <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    fn_q    <= funct;
                    neg_q   <= res_neg;
                    out_tag <= in_tag;
                    b_q     <= mag2;
                    acc     <= {{XLEN{1'b0}}, mag1};
                    prem    <= '0;
                    cnt     <= '0;
                    if (direct) begin
                        res       <= special ? spec_res : fast_res;
                        out_valid <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (fn_q[2]) begin
                        // Restoring step: keep the trial difference only when it stayed non-negative
                        prem <= ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
                        acc  <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~ddiff[XLEN]};
                    end else begin
                        acc <= {msum, acc[XLEN-1:1]};
                    end
                end
                FIX: begin
                    res       <= fix_res;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
